// File: rtl/reg_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_pkg
//  Description : Shared types and constants for the register write-back unit.
//                Holds the register-file geometry, the buffered load entry
//                format and the write-source encoding used by arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  // One buffered load response: destination register plus its data.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Which source wins the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LQ   = 2'd2,
    SRC_BYP  = 2'd3
  } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_load_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_load_fifo
//  Description : Synchronous FIFO of wb_entry_t holding load responses that
//                lost write-port arbitration. DEPTH must be a power of two so
//                the pointers wrap naturally.
//  Ports       : clk, rst (async, active-low)
//                push/push_data - enqueue (ignored when full)
//                pop/head       - dequeue / current oldest entry
//                full, empty, count - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_load_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_data,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/reg_wb_unit.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_unit
//  Description : Sole driver of the register-file write port. Merges ALU
//                results with variable-latency load responses, buffers loads
//                that lose arbitration and tracks outstanding loads per
//                register so decode can stall on them.
//  Ports       : clk, rst (async, active-low)
//                alu_we/alu_rd/alu_result      - single-cycle ALU writeback
//                ld_issue/ld_issue_rd          - load issued to memory
//                ld_valid/ld_rd/ld_data        - load response
//                ld_ready                      - response can be accepted
//                A3/WD3/WE3                    - registered write port
//                busy                          - outstanding-load scoreboard
//                stall_req                     - buffer full, hold ALU
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_unit
  import reg_wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_we,
  input  logic [4:0]        alu_rd,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              ld_issue,
  input  logic [4:0]        ld_issue_rd,
  input  logic              ld_valid,
  input  logic [4:0]        ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              ld_ready,
  output logic [4:0]        A3,
  output logic [XLEN-1:0]   WD3,
  output logic              WE3,
  output logic [NREGS-1:0]  busy,
  output logic              stall_req
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;

  wb_src_e         src;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data;
  logic            alu_wr;
  logic            ld_acc;
  logic            ld_keep;
  logic            lq_push;
  logic            lq_pop;
  logic            lq_full;
  logic            lq_empty;
  logic [CW-1:0]   lq_count;
  wb_entry_t       lq_head;
  wb_entry_t       lq_in;
  logic [NREGS-1:0] busy_set;
  logic [NREGS-1:0] busy_clr;
  logic [NREGS-1:0] busy_next;

  // Ready depends only on registered occupancy, never on ld_valid.
  assign ld_ready  = (lq_count < CW'(LQ_DEPTH));
  assign stall_req = lq_full;

  assign alu_wr  = alu_we && (alu_rd != '0);
  assign ld_acc  = ld_valid && ld_ready;
  // Responses to x0 are accepted to free the memory side, then dropped.
  assign ld_keep = ld_acc && (ld_rd != '0);
  assign lq_in   = '{rd: ld_rd, data: ld_data};

  wb_load_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .rst       (rst),
    .push      (lq_push),
    .push_data (lq_in),
    .pop       (lq_pop),
    .head      (lq_head),
    .full      (lq_full),
    .empty     (lq_empty),
    .count     (lq_count)
  );

  // Fixed-priority arbitration: ALU, then oldest buffered load, then a fresh
  // load that can bypass the empty buffer. A fresh load that does not win is
  // buffered; it may be pushed in the same cycle the head is popped.
  always_comb begin
    src     = SRC_NONE;
    wr_rd   = '0;
    wr_data = '0;
    lq_push = 1'b0;
    lq_pop  = 1'b0;
    if (alu_wr) begin
      src     = SRC_ALU;
      wr_rd   = alu_rd;
      wr_data = alu_result;
      lq_push = ld_keep;
    end else if (!lq_empty) begin
      src     = SRC_LQ;
      wr_rd   = lq_head.rd;
      wr_data = lq_head.data;
      lq_pop  = 1'b1;
      lq_push = ld_keep;
    end else if (ld_keep) begin
      src     = SRC_BYP;
      wr_rd   = ld_rd;
      wr_data = ld_data;
    end
  end

  // A3/WD3 hold their last value on idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      A3  <= '0;
      WD3 <= '0;
      WE3 <= 1'b0;
    end else begin
      WE3 <= (src != SRC_NONE);
      if (src != SRC_NONE) begin
        A3  <= wr_rd;
        WD3 <= wr_data;
      end
    end
  end

  // The clear lands on the same edge that presents the load on WE3, so busy
  // drops in the very cycle the register file is written. Set wins over clear.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (src == SRC_LQ || src == SRC_BYP) busy_clr[wr_rd] = 1'b1;
    if (ld_issue && ld_issue_rd != '0) busy_set[ld_issue_rd] = 1'b1;
    busy_next    = (busy & ~busy_clr) | busy_set;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_next;
  end

  // Obligations on the surrounding core; this unit does not recover from them.
  a_issue_not_busy: assert property (@(posedge clk) disable iff (!rst)
    !(ld_issue && ld_issue_rd != '0 && busy[ld_issue_rd]));
  a_alu_not_busy: assert property (@(posedge clk) disable iff (!rst)
    !(alu_we && alu_rd != '0 && busy[alu_rd]));
  a_alu_not_stalled: assert property (@(posedge clk) disable iff (!rst)
    !(alu_we && stall_req));
  a_resp_busy: assert property (@(posedge clk) disable iff (!rst)
    !(ld_valid && ld_rd != '0 && !busy[ld_rd]));

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_wb_unit
//  Description : Self-checking bench for reg_wb_unit. A queue-based reference
//                model produces the expected write for every clock edge; a
//                negedge monitor pops and compares against the write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_unit;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [31:0] busy;
  logic        stall_req;

  reg_wb_unit dut (
    .clk         (clk),
    .rst         (rst),
    .alu_we      (alu_we),
    .alu_rd      (alu_rd),
    .alu_result  (alu_result),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .ld_valid    (ld_valid),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .A3          (A3),
    .WD3         (WD3),
    .WE3         (WE3),
    .busy        (busy),
    .stall_req   (stall_req)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; bit [4:0] rd; bit [31:0] data; } exp_t;
  typedef struct { bit [4:0] rd; bit [31:0] data; } ld_t;

  exp_t      expq[$];
  ld_t       lq[$];
  bit [4:0]  pending[$];
  bit [31:0] mbusy;
  bit        started;
  bit        last_acc;
  bit        hold_valid;
  int        checks;
  int        failures;
  exp_t      mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: one call per rising edge, using the inputs in force.
  task automatic model_edge();
    exp_t e;
    ld_t  l;
    bit   acc;
    e = '{we: 1'b0, rd: 5'd0, data: 32'd0};
    last_acc = 1'b0;
    if (!rst) begin
      lq.delete();
      mbusy = '0;
      expq.push_back(e);
      return;
    end
    acc = ld_valid && (lq.size() < D);
    last_acc = acc;
    if (alu_we && alu_rd != 0) begin
      e = '{we: 1'b1, rd: alu_rd, data: alu_result};
      if (acc && ld_rd != 0) lq.push_back('{rd: ld_rd, data: ld_data});
    end else if (lq.size() > 0) begin
      l = lq.pop_front();
      e = '{we: 1'b1, rd: l.rd, data: l.data};
      mbusy[l.rd] = 1'b0;
      if (acc && ld_rd != 0) lq.push_back('{rd: ld_rd, data: ld_data});
    end else if (acc && ld_rd != 0) begin
      e = '{we: 1'b1, rd: ld_rd, data: ld_data};
      mbusy[ld_rd] = 1'b0;
    end
    if (ld_issue && ld_issue_rd != 0) mbusy[ld_issue_rd] = 1'b1;
    expq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    alu_we = 0; alu_rd = 0; alu_result = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  // Asynchronous reset in the middle of a cycle; the pending expected write is
  // replaced because the reset wipes it before it can be observed.
  task automatic reset_now();
    rst = 1'b0;
    lq.delete();
    mbusy = '0;
    pending.delete();
    hold_valid = 1'b0;
    expq.delete();
    expq.push_back('{we: 1'b0, rd: 5'd0, data: 32'd0});
    #1;
    chk("midrst_we3", WE3, 0);
    chk("midrst_busy", busy, 0);
  endtask

  function automatic bit [4:0] pick_free();
    bit [4:0] r;
    for (int t = 0; t < 64; t++) begin
      r = 5'($urandom % 32);
      if (!mbusy[r]) return r;
    end
    return 5'd0;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        chk("we3", WE3, mon_e.we);
        if (mon_e.we) begin
          chk("a3", A3, mon_e.rd);
          chk("wd3", WD3, mon_e.data);
        end
      end
      chk("busy_sb", busy, mbusy);
      chk("ld_ready", ld_ready, lq.size() < D);
      chk("stall_req", stall_req, lq.size() == D);
    end
  end

  initial begin
    int  idx;
    int  alu_n;
    bit  saw_full;
    int  k;
    bit [4:0] r;

    clear_inputs();
    hold_valid = 0;
    #2 rst = 1'b0;
    started = 1'b1;

    // Reset held while an ALU write is being requested.
    alu_we = 1; alu_rd = 5; alu_result = 32'h55;
    repeat (3) step();
    chk("rst_we3", WE3, 0);
    chk("rst_a3", A3, 0);
    chk("rst_wd3", WD3, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_stall", stall_req, 0);
    rst = 1'b1;
    step();
    chk("rel_we3", WE3, 1);
    chk("rel_a3", A3, 5);

    // ALU only.
    alu_rd = 9; alu_result = 32'h20;
    step();
    chk("alu_a3", A3, 9);
    chk("alu_wd3", WD3, 32'h20);
    alu_rd = 0;
    step();
    chk("alu_x0_we3", WE3, 0);
    clear_inputs();

    // Load bypass and scoreboard.
    ld_issue = 1; ld_issue_rd = 6;
    step();
    clear_inputs();
    chk("issue_busy6", busy[6], 1);
    step(); step();
    ld_valid = 1; ld_rd = 6; ld_data = 32'h40;
    step();
    clear_inputs();
    chk("byp_we3", WE3, 1);
    chk("byp_a3", A3, 6);
    chk("byp_wd3", WD3, 32'h40);
    chk("byp_busy6", busy[6], 0);

    // ALU and load in the same cycle.
    ld_issue = 1; ld_issue_rd = 5;
    step();
    clear_inputs();
    alu_we = 1; alu_rd = 1; alu_result = 3;
    ld_valid = 1; ld_rd = 5; ld_data = 32'h20;
    step();
    clear_inputs();
    chk("cfl_a3_alu", A3, 1);
    chk("cfl_wd3_alu", WD3, 3);
    step();
    chk("cfl_a3_ld", A3, 5);
    chk("cfl_wd3_ld", WD3, 32'h20);
    chk("cfl_ready", ld_ready, 1);

    // Backpressure: ALU traffic keeps loads buffered until the buffer fills.
    for (int i = 0; i < 3; i++) begin
      ld_issue = 1; ld_issue_rd = 5'(10 + i);
      step();
    end
    clear_inputs();
    idx = 0; alu_n = 0; saw_full = 0;
    for (int c = 0; c < 20 && (idx < 3 || lq.size() > 0); c++) begin
      alu_we = (alu_n < 4) && (lq.size() < D);
      alu_rd = 5'(1 + alu_n);
      alu_result = 32'(c);
      ld_valid = (idx < 3);
      ld_rd = 5'(10 + idx);
      ld_data = 32'h100 + 32'(idx);
      step();
      if (alu_we) alu_n++;
      if (last_acc) idx++;
      if (!ld_ready && stall_req) saw_full = 1;
    end
    clear_inputs();
    chk("bp_saw_full", saw_full, 1);
    step();
    chk("bp_drained_ready", ld_ready, 1);

    // Reset while two loads sit in the buffer.
    ld_issue = 1; ld_issue_rd = 10;
    step();
    ld_issue_rd = 11;
    step();
    clear_inputs();
    chk("mid_busy", busy, 32'h0C00);
    alu_we = 1; alu_rd = 1; alu_result = 32'h77;
    ld_valid = 1; ld_rd = 10; ld_data = 32'hA0;
    step();
    alu_rd = 2; ld_rd = 11; ld_data = 32'hB0;
    step();
    clear_inputs();
    chk("mid_stall", stall_req, 1);
    reset_now();
    step(); step();
    rst = 1'b1;
    repeat (4) step();
    chk("mid_rel_ready", ld_ready, 1);

    // Randomized traffic respecting the core obligations.
    for (int c = 0; c < 3000; c++) begin
      alu_we = 0; ld_issue = 0;
      if (($urandom % 3) == 0 && lq.size() < D) begin
        alu_we = 1; alu_rd = pick_free(); alu_result = $urandom;
      end
      if (!hold_valid && ($urandom % 3) == 0) begin
        if (pending.size() > 0 && ($urandom % 8) != 0) begin
          k = int'($urandom % pending.size());
          ld_rd = pending[k];
          pending.delete(k);
        end else begin
          ld_rd = 0;
        end
        ld_data = $urandom;
        hold_valid = 1;
      end
      ld_valid = hold_valid;
      if (($urandom % 4) == 0) begin
        r = pick_free();
        if (!(alu_we && r == alu_rd)) begin
          ld_issue = 1; ld_issue_rd = r;
        end
      end
      step();
      if (ld_issue && ld_issue_rd != 0) pending.push_back(ld_issue_rd);
      if (hold_valid && last_acc) hold_valid = 0;
    end

    // Drain every outstanding load with no competing ALU traffic.
    clear_inputs();
    for (int c = 0; c < 400 && (pending.size() > 0 || hold_valid || lq.size() > 0); c++) begin
      if (!hold_valid && pending.size() > 0) begin
        ld_rd = pending.pop_front();
        ld_data = $urandom;
        hold_valid = 1;
      end
      ld_valid = hold_valid;
      step();
      if (hold_valid && last_acc) hold_valid = 0;
    end
    clear_inputs();
    repeat (2) step();
    chk("final_busy", busy, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_wb_unit.md
Name: reg_wb_unit

Overview:
- Writer-side companion to the register file: it is the only block that drives the register file write port (A3/WD3/WE3).
- Merges single-cycle ALU results with variable-latency load responses from data memory.
- Buffers load responses that lose arbitration and keeps a per-register busy scoreboard so decode can stall on pending loads.
- Sits between execute/memory and the register file write port.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, architectural register count; address width is 5.
- LQ_DEPTH, 2, load response buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_we  in  1  ALU result valid this cycle.
- alu_rd  in  5  ALU destination register.
- alu_result  in  XLEN  ALU result data.
- ld_issue  in  1  load issued to memory this cycle.
- ld_issue_rd  in  5  destination of the issued load.
- ld_valid  in  1  load response valid.
- ld_rd  in  5  load response destination.
- ld_data  in  XLEN  load response data.
- ld_ready  out  1  unit can accept a load response; high when the buffer is not full.
- A3  out  5  register file write address, registered.
- WD3  out  XLEN  register file write data, registered.
- WE3  out  1  register file write enable, registered.
- busy  out  NREGS  bit i set means a load to x(i) is outstanding.
- stall_req  out  1  buffer full; core must hold further ALU writebacks.

Behaviour:
- Reset (rst=0, asynchronous):
  - A3=0, WD3=0, WE3=0, busy=0, buffer empty, ld_ready=1, stall_req=0.
  - In-flight buffered loads are discarded.
- Load acceptance: a load response is accepted when ld_valid && ld_ready.
- Per-cycle arbitration, evaluated on each rising edge; the result drives A3/WD3/WE3 in the next cycle (latency 1):
  1. If alu_we && alu_rd!=0, write the ALU result. Any accepted load is pushed into the buffer.
  2. Else if the buffer is non-empty, pop the head and write it. Any accepted load is pushed into the buffer; push and pop may happen in the same cycle.
  3. Else if a load is accepted with ld_rd!=0, write it directly (bypass, no buffer entry).
  4. Else WE3=0; A3/WD3 hold their previous values.
- x0 handling: writes with rd=0 never assert WE3 and are never buffered. A load with rd=0 is accepted and dropped.
- Buffer order: strict FIFO order among loads.
  - Pointers wrap modulo LQ_DEPTH.
  - The count saturates only at LQ_DEPTH; the full flag blocks pushes.
- Ready and stall:
  - ld_ready = (count < LQ_DEPTH), purely from registered state with no combinational path from ld_valid.
  - stall_req = (count == LQ_DEPTH).
- Scoreboard:
  - busy[ld_issue_rd] sets on ld_issue when ld_issue_rd!=0.
  - busy[rd] clears in the cycle the load write for rd is presented on WE3.
  - If a set and a clear hit the same bit in one cycle, set wins.
  - busy[0] is always 0.
- Core obligations, checked by assertions rather than handled in RTL:
  - No ld_issue to a register already busy.
  - No alu_we to a busy register.
  - No alu_we while stall_req=1.
  - No ld_valid for a register that is not busy, unless rd=0.
- WE3 is asserted for at most one source per cycle; the ALU write is never delayed by this unit.

Decomposition:
- Package reg_wb_pkg:
  - XLEN, REG_AW=5, NREGS.
  - Packed struct wb_entry_t {rd[4:0], data[XLEN-1:0]}.
  - Source enum {SRC_NONE, SRC_ALU, SRC_LQ, SRC_BYP}.
- One sub-module: wb_load_fifo. It is a parameterized synchronous FIFO of wb_entry_t with push, pop, full, empty and count. reg_wb_unit holds the arbitration, output registers and scoreboard.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 3 cycles while driving alu_we=1, alu_rd=5.
  - Expect: WE3=0, busy=0, ld_ready=1. After release, the ALU write appears the following cycle with A3=5.
- ALU only:
  - Stimulus: alu_we=1, alu_rd=9, alu_result=32'h20.
  - Expect: next cycle WE3=1, A3=9, WD3=32'h20.
  - Stimulus: alu_rd=0.
  - Expect: WE3=0.
- Load bypass and scoreboard:
  - Stimulus: ld_issue rd=6, then busy[6]=1; 3 cycles later ld_valid rd=6, data=32'h40.
  - Expect: next cycle WE3=1, A3=6, WD3=32'h40, busy[6] cleared the same cycle.
- Conflict:
  - Stimulus: same cycle alu_we rd=1 data=3 and ld_valid rd=5 data=32'h20.
  - Expect: cycle+1 writes x1=3; cycle+2 writes x5=32'h20; count returns to 0.
- Backpressure:
  - Stimulus: alu_we every cycle for 4 cycles plus ld_valid to rd=10, 11, 12.
  - Expect: after 2 pushes ld_ready=0 and stall_req=1, and the rd=12 response is held off until it is accepted. The bench then drops alu_we, as required by the stall_req obligation. Loads write in order 10, 11, 12.
- Reset mid-operation:
  - Stimulus: buffer holds 2 entries and busy=0x0C00; assert rst=0.
  - Expect: immediately WE3=0, busy=0, and count=0 after release; the discarded loads are never written.
